muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits (legal range 8..64, even).
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port Op, input, 2 bits: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 The block SHALL have port A, input, WIDTH bits: multiplicand or dividend.
REQ-007 The block SHALL have port B, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have port Busy, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port Div_Zero, output, 1 bit: one-cycle divide-by-zero pulse, coincident with Done.
REQ-011 The block SHALL have port HI_Out, output, WIDTH bits: product high half, or remainder.
REQ-012 The block SHALL have port LO_Out, output, WIDTH bits: product low half, or quotient.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE.
REQ-014 In IDLE, a rising edge with Start=1 SHALL latch Op and the operand magnitudes, record the result signs, clear the iteration counter, and enter MUL (Op[1]=0) or DIV (Op[1]=1).
REQ-015 MUL SHALL run exactly WIDTH shift-add iterations, one per cycle, on a 2*WIDTH-bit accumulator, then enter FIX.
REQ-016 DIV SHALL run exactly WIDTH restoring shift-subtract iterations, one per cycle, then enter FIX.
REQ-017 FIX SHALL apply sign correction in one cycle, then enter DONE.
- MULT: negate the 2*WIDTH-bit product when the operand signs differ.
- DIV: negate the quotient when the operand signs differ; the remainder takes the dividend's sign.
REQ-018 DONE SHALL last one cycle: HI_Out and LO_Out load, Done=1, then the FSM returns to IDLE.
REQ-019 Latency SHALL be WIDTH+2 edges from the edge sampling Start to the edge raising Done; for WIDTH=32 that is 34.
REQ-020 Busy SHALL be 1 in MUL, DIV, FIX and DONE, and 0 in IDLE.
REQ-021 Start while Busy=1 SHALL be ignored with no side effects; a back-to-back Start is accepted the cycle after Done.
REQ-022 Results SHALL be as follows:
- MULT/MULTU: {HI_Out,LO_Out} = full 2*WIDTH-bit product.
- DIV/DIVU: LO_Out = quotient truncated toward zero, HI_Out = remainder.
REQ-023 Signed DIV of the most negative value by -1 SHALL return LO_Out = most negative value (wrap) and HI_Out = 0, with no flag.
REQ-024 Divide-by-zero (B=0 with Op[1]=1) SHALL skip the iterations: the FSM goes IDLE->DONE, and Done=Div_Zero=1 one edge after Start, with HI_Out/LO_Out unchanged.
REQ-025 HI_Out and LO_Out SHALL change only in DONE (non-zero-divisor case) or on reset, and SHALL hold between operations.
REQ-026 A, B and Op changing after the Start edge SHALL NOT affect the result in progress.

Reset
REQ-027 Reset=0 SHALL immediately, independent of Clock, force IDLE with Busy=0, Done=0, Div_Zero=0, HI_Out=0, LO_Out=0, and the internal accumulator and counter cleared.
REQ-028 Reset asserted mid-operation SHALL abort it with no Done pulse; the first Start after Reset deasserts SHALL begin a fresh operation.
REQ-029 Reset deassertion SHALL be sampled synchronously; Start is honoured no earlier than the first rising edge after deassertion.

Verification
REQ-030 With WIDTH=32, the bench SHALL cover these directed scenarios:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 34 edges, Done pulse, HI_Out=0xFFFFFFFF, LO_Out=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI_Out=0xFFFFFFFE, LO_Out=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO_Out=0xFFFFFFFD (-3), HI_Out=0xFFFFFFFF (-1); DIVU with the same operands -> LO_Out=0x7FFFFFFC, HI_Out=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO_Out=0x80000000, HI_Out=0, Div_Zero=0.
- DIVU A=5, B=0 -> Done=Div_Zero=1 one edge after Start, prior HI_Out/LO_Out retained; a Start pulsed while Busy in another run is ignored.
- Reset low at iteration 10 of a MULT -> outputs zero at once, no Done; next MULT 3*4 -> LO_Out=12, HI_Out=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The testbench drives through master; the unit connects as slave.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic             Div_Zero;
   logic [WIDTH-1:0] HI_Out;
   logic [WIDTH-1:0] LO_Out;

   modport master (
      output Start, Op, A, B,
      input  Busy, Done, Div_Zero, HI_Out, LO_Out
   );

   modport slave (
      input  Start, Op, A, B,
      output Busy, Done, Div_Zero, HI_Out, LO_Out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring),
// one bit per cycle on magnitudes, followed by a single sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         Clock,
   input  logic         Reset,
   muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic                 dz_pend_q, dz_pend_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div_zero_q, div_zero_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic signed [WIDTH:0] div_trial;

   function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   // Op[0]=1 selects the unsigned variants, so operands are never negative there.
   assign a_neg = !bus.Op[0] && bus.A[WIDTH-1];
   assign b_neg = !bus.Op[0] && bus.B[WIDTH-1];
   assign a_mag = cneg_w(bus.A, a_neg);
   assign b_mag = cneg_w(bus.B, b_neg);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      dz_pend_d  = dz_pend_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      mul_sum    = '0;
      div_trial  = '0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               is_div_d  = bus.Op[1];
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               cnt_d     = '0;
               dz_pend_d = bus.Op[1] && (bus.B == '0);
               // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
               if (bus.Op[1]) begin
                  opnd_d = b_mag;
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
               end else begin
                  opnd_d = a_mag;
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
               end
               if (bus.Op[1] && (bus.B == '0)) state_d = DONE;
               else if (bus.Op[1])              state_d = DIV;
               else                             state_d = MUL;
            end
         end
         MUL: begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_d = FIX;
         end
         DIV: begin
            div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
            // Negative trial means the divisor did not fit: restore by keeping the shifted value.
            if (div_trial[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            else                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) acc_d = {cneg_w(acc_q[2*WIDTH-1:WIDTH], rem_neg_q),
                                   cneg_w(acc_q[WIDTH-1:0], neg_q)};
            else          acc_d = cneg_2w(acc_q, neg_q);
            state_d = DONE;
         end
         DONE: begin
            done_d     = 1'b1;
            div_zero_d = dz_pend_q;
            if (!dz_pend_q) begin
               hi_d = acc_q[2*WIDTH-1:WIDTH];
               lo_d = acc_q[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         dz_pend_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         dz_pend_q  <= dz_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Div_Zero = div_zero_q;
   assign bus.HI_Out   = hi_q;
   assign bus.LO_Out   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
   localparam int WIDTH = 32;

   logic Clock = 1'b0;
   logic Reset = 1'b0;

   muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
   muldiv_unit #(.WIDTH(WIDTH)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   logic [31:0] hi_prev = '0;
   logic [31:0] lo_prev = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: native 64-bit arithmetic; signed / and % truncate toward zero.
   task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint sa, sb, q, r;
      logic [63:0] p, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      dz = 1'b0;
      hi = hi_prev;
      lo = lo_prev;
      case (op)
         2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == 32'h0) dz = 1'b1;
            else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endtask

   // Starts at the current time (may be while the previous Done is visible) and
   // returns just after the edge that raised Done.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      logic [31:0] ehi, elo;
      logic edz;
      int lat;
      bit seen;
      ref_model(op, a, b, ehi, elo, edz);
      bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
      @(posedge Clock); #1;
      check({tag, "_busy_start"}, 64'(bus.Busy), 64'(1));
      check({tag, "_done_prev_low"}, 64'(bus.Done), 64'(0));
      bus.Start = 1'b0; bus.Op = 2'($urandom); bus.A = $urandom; bus.B = $urandom;
      lat = 0; seen = 0;
      while (!seen && lat < 200) begin
         if (poke && lat == 3) begin
            bus.Start = 1'b1; bus.Op = 2'($urandom); bus.A = $urandom; bus.B = 32'h0;
         end else begin
            bus.Start = 1'b0;
         end
         if (lat == 10) begin
            check({tag, "_hold_hi"}, 64'(bus.HI_Out), 64'(hi_prev));
            check({tag, "_hold_lo"}, 64'(bus.LO_Out), 64'(lo_prev));
         end
         @(posedge Clock); #1;
         lat++;
         if (bus.Done) seen = 1;
      end
      bus.Start = 1'b0;
      check({tag, "_latency"}, 64'(lat), edz ? 64'(1) : 64'(WIDTH + 2));
      check({tag, "_hi"}, 64'(bus.HI_Out), 64'(ehi));
      check({tag, "_lo"}, 64'(bus.LO_Out), 64'(elo));
      check({tag, "_div_zero"}, 64'(bus.Div_Zero), 64'(edz));
      check({tag, "_busy_end"}, 64'(bus.Busy), 64'(0));
      hi_prev = ehi;
      lo_prev = elo;
   endtask

   initial begin
      bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
      #1;
      check("rst_busy", 64'(bus.Busy), 64'(0));
      check("rst_done", 64'(bus.Done), 64'(0));
      check("rst_hi", 64'(bus.HI_Out), 64'(0));
      check("rst_lo", 64'(bus.LO_Out), 64'(0));
      repeat (3) @(posedge Clock);
      @(negedge Clock); Reset = 1'b1;

      run_op("mult_neg2x3", 2'b00, 32'hFFFFFFFE, 32'h00000003, 1'b0);
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      run_op("divu_7_2", 2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op("divu_by0", 2'b11, 32'h00000005, 32'h00000000, 1'b0);
      run_op("div_by0", 2'b10, 32'h80000000, 32'h00000000, 1'b0);
      check("dz_pulse_low", 64'(bus.Div_Zero), 64'(1));
      run_op("mult_poke", 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);
      run_op("div_poke", 2'b10, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         logic [31:0] a, b;
         op = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op("rand", op, a, b, ($urandom_range(0, 3) == 0));
      end

      // Abort a multiply part-way through with an asynchronous reset.
      @(negedge Clock);
      bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'h0000BEEF; bus.B = 32'h00001234;
      @(posedge Clock); #1;
      bus.Start = 1'b0;
      repeat (10) @(posedge Clock);
      #3 Reset = 1'b0;
      #1;
      check("abort_busy", 64'(bus.Busy), 64'(0));
      check("abort_hi", 64'(bus.HI_Out), 64'(0));
      check("abort_lo", 64'(bus.LO_Out), 64'(0));
      check("abort_done", 64'(bus.Done), 64'(0));
      repeat (WIDTH + 4) @(posedge Clock);
      #1;
      check("abort_no_done", 64'(bus.Done), 64'(0));
      @(negedge Clock); Reset = 1'b1;
      hi_prev = '0;
      lo_prev = '0;
      run_op("mult_3x4", 2'b00, 32'h00000003, 32'h00000004, 1'b0);
      check("mult_3x4_lo_val", 64'(bus.LO_Out), 64'(12));

      @(posedge Clock); #1;
      check("done_pulse_width", 64'(bus.Done), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
